// File: rtl/sum_display_driver.sv
// Purpose: latch adder operands/result on Load and scan them onto a 4-digit common-anode 7-seg display.
// Latency: outputs registered, one cycle after the Cnt/Dig/capture state they reflect; Load visible next cycle.
// Backpressure: none; Load is a free-running strobe and the scan never stalls.
// Optional build macro SUM_DECIMAL_EN: digits 1..0 show the 5-bit result in decimal (tens blanked when 0).
module sum_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] InputX,
  input  logic [3:0] InputY,
  input  logic [3:0] Sum,
  input  logic       Cout,
  input  logic       Load,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Dp
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    y_q, y_d;
  logic [4:0]    r_q, r_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [3:0]    nib;
  logic          blank;

  // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef SUM_DECIMAL_EN
  logic [1:0] tens;
  logic [4:0] rem;

  // Binary 0..31 to tens/ones by compare-subtract; tens never exceeds 3.
  always_comb begin
    tens = 2'd0;
    rem  = r_q;
    if (r_q >= 5'd30) begin
      tens = 2'd3;
      rem  = r_q - 5'd30;
    end else if (r_q >= 5'd20) begin
      tens = 2'd2;
      rem  = r_q - 5'd20;
    end else if (r_q >= 5'd10) begin
      tens = 2'd1;
      rem  = r_q - 5'd10;
    end
  end
`endif

  // Select the nibble for the digit currently being scanned.
  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    case (dig_q)
      2'd3: nib = x_q;
      2'd2: nib = y_q;
`ifdef SUM_DECIMAL_EN
      2'd1: begin
        nib   = {2'b00, tens};
        blank = (tens == 2'd0);
      end
      default: nib = rem[3:0];
`else
      2'd1: nib = {3'b000, r_q[4]};
      default: nib = r_q[3:0];
`endif
    endcase
  end

  // Next-state: capture, refresh counter/digit advance, and registered display outputs.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    r_d   = r_q;
    cnt_d = cnt_q + CW'(1);
    dig_d = dig_q;
    if (Load) begin
      x_d = InputX;
      y_d = InputY;
      r_d = {Cout, Sum};
    end
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end
    // First cycle of every slot is blanked so the previous digit's segments do not ghost.
    an_d  = (cnt_q == '0) ? 4'b1111 : ~(4'b0001 << dig_q);
    seg_d = blank ? 7'b1111111 : hex_to_seg(nib);
    dp_d  = 1'b1;
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
      dig_q <= 2'd0;
      x_q   <= 4'h0;
      y_q   <= 4'h0;
      r_q   <= 5'd0;
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      x_q   <= x_d;
      y_q   <= y_d;
      r_q   <= r_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign An  = an_q;
  assign Seg = seg_q;
  assign Dp  = dp_q;

endmodule

// File: tb/tb_sum_display_driver.sv
// Bench for sum_display_driver at REFRESH_DIV=4: model tracks edges since reset release
// and the captured operands; expected display derived from slot position arithmetic.
module tb_sum_display_driver;

  localparam int RD = 4;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [3:0] InputX = 4'h0;
  logic [3:0] InputY = 4'h0;
  logic [3:0] Sum = 4'h0;
  logic       Cout = 1'b0;
  logic       Load = 1'b0;
  logic [3:0] An;
  logic [6:0] Seg;
  logic       Dp;

  sum_display_driver #(.REFRESH_DIV(RD)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InputX(InputX), .InputY(InputY),
    .Sum(Sum), .Cout(Cout), .Load(Load), .An(An), .Seg(Seg), .Dp(Dp)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: edges since release, captured values.
  int n  = 0;
  int mx = 0, my = 0, mr = 0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  int exp_d, exp_slot;

  function automatic logic [6:0] ref_hex(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] ref_digit(input int d);
    case (d)
      3: return ref_hex(mx);
      2: return ref_hex(my);
`ifdef SUM_DECIMAL_EN
      1: return (mr / 10 == 0) ? 7'b1111111 : ref_hex(mr / 10);
      default: return ref_hex(mr % 10);
`else
      1: return ref_hex(mr / 16);
      default: return ref_hex(mr % 16);
`endif
    endcase
  endfunction

  // One clock: drive inputs at negedge, predict output of the coming edge, advance model.
  task automatic tick(input logic ld, input int x, input int y, input int r);
    Load   = ld;
    InputX = 4'(x);
    InputY = 4'(y);
    Sum    = 4'(r % 16);
    Cout   = (r >= 16);
    exp_slot = n % RD;
    exp_d    = (n / RD) % 4;
    exp_an   = (exp_slot == 0) ? 4'd15 : 4'(15 - (1 << exp_d));
    exp_seg  = ref_digit(exp_d);
    @(posedge Clk);
    if (ld) begin
      mx = x; my = y; mr = r;
    end
    n++;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Load = 1'b1; InputX = 4'hF; InputY = 4'hE; Sum = 4'hD; Cout = 1'b1;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (An !== 4'b1111 || Seg !== 7'b1111111 || Dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_initial: An=%b Seg=%b Dp=%b, want 1111 1111111 1", An, Seg, Dp);
    end
    Rst_n = 1'b1; n = 0; mx = 0; my = 0; mr = 0;
    // Run to post-edge Cnt=2, Dig=2 (10 edges), then reset asynchronously mid-slot.
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 0, 0, 0);
      if (i < 2) begin
        n_checks++;
        if (An !== (i == 0 ? 4'b1111 : 4'b1110)) begin
          n_fail++;
          $display("FAIL reset_release_%0d: An=%b want %b", i, An, (i == 0 ? 4'b1111 : 4'b1110));
        end
      end
    end
    n_checks++;
    if (An !== 4'b1011) begin
      n_fail++;
      $display("FAIL pre_reset_dig2: An=%b want 1011", An);
    end
    #2 Rst_n = 1'b0;
    #1;
    n_checks++;
    if (An !== 4'b1111 || Seg !== 7'b1111111 || Dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: An=%b Seg=%b Dp=%b, want 1111 1111111 1", An, Seg, Dp);
    end
    Load = 1'b1; InputX = 4'h9; Sum = 4'h9;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1; n = 0; mx = 0; my = 0; mr = 0;
    tick(1'b0, 0, 0, 0);
    n_checks++;
    if (An !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_blank_first: An=%b want 1111", An);
    end
    tick(1'b0, 0, 0, 0);
    n_checks++;
    if (An !== 4'b1110 || Seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_digit0: An=%b Seg=%b want 1110 1000000", An, Seg);
    end
  endtask

  task automatic test_hex_scan();
    int blanks;
    logic [6:0] want;
    tick(1'b1, 10, 5, 31);
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 10, 5, 31);
      n_checks++;
      if (An !== exp_an || Seg !== exp_seg || Dp !== 1'b1) begin
        n_fail++;
        $display("FAIL hex_scan_model cyc %0d: An=%b Seg=%b Dp=%b want %b %b 1", i, An, Seg, Dp, exp_an, exp_seg);
      end
      if (An === 4'b1111) blanks++;
      if (exp_slot != 0) begin
        case (exp_d)
          3: want = 7'b0001000;
          2: want = 7'b0010010;
`ifdef SUM_DECIMAL_EN
          1: want = 7'b0110000;
          default: want = 7'b1111001;
`else
          1: want = 7'b1111001;
          default: want = 7'b0001110;
`endif
        endcase
        n_checks++;
        if (Seg !== want) begin
          n_fail++;
          $display("FAIL hex_scan_digit%0d: Seg=%b want %b", exp_d, Seg, want);
        end
      end
    end
    n_checks++;
    if (blanks != 8) begin
      n_fail++;
      $display("FAIL hex_scan_blanks: got %0d blank cycles in 32, want 8", blanks);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 3, 0, 0);
      n_checks++;
      if (An !== exp_an || Seg !== exp_seg) begin
        n_fail++;
        $display("FAIL hold cyc %0d: An=%b Seg=%b want %b %b", i, An, Seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_load_wrap();
    while (n % 16 != 11) tick(1'b0, mx, my, mr);
    tick(1'b1, 7, my, mr);
    for (int i = 0; i < RD; i++) begin
      tick(1'b0, mx, my, mr);
      n_checks++;
      if (Seg !== 7'b1111000 || An !== (i == 0 ? 4'b1111 : 4'b0111)) begin
        n_fail++;
        $display("FAIL load_wrap cyc %0d: An=%b Seg=%b want %b 1111000", i, An, Seg, (i == 0 ? 4'b1111 : 4'b0111));
      end
    end
  endtask

  task automatic test_dig_wrap();
    while (n % 16 != 15) tick(1'b0, mx, my, mr);
    tick(1'b0, mx, my, mr);
    tick(1'b0, mx, my, mr);
    n_checks++;
    if (An !== 4'b1111) begin
      n_fail++;
      $display("FAIL dig_wrap_blank: An=%b want 1111", An);
    end
    tick(1'b0, mx, my, mr);
    n_checks++;
    if (An !== 4'b1110 || Seg !== exp_seg) begin
      n_fail++;
      $display("FAIL dig_wrap_d0: An=%b Seg=%b want 1110 %b", An, Seg, exp_seg);
    end
  endtask

  task automatic test_decimal(input int r);
    logic [6:0] w1, w0;
`ifdef SUM_DECIMAL_EN
    w1 = (r == 31) ? 7'b0110000 : 7'b1111111;
    w0 = (r == 31) ? 7'b1111001 : 7'b1111000;
`else
    w1 = (r == 31) ? 7'b1111001 : 7'b1000000;
    w0 = (r == 31) ? 7'b0001110 : 7'b1111000;
`endif
    tick(1'b1, mx, my, r);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, mx, my, r);
      n_checks++;
      if (An !== exp_an || Seg !== exp_seg) begin
        n_fail++;
        $display("FAIL decimal_%0d_model cyc %0d: An=%b Seg=%b want %b %b", r, i, An, Seg, exp_an, exp_seg);
      end
      if (exp_slot != 0 && exp_d < 2) begin
        n_checks++;
        if (Seg !== (exp_d == 1 ? w1 : w0) || An !== (exp_d == 1 ? 4'b1101 : 4'b1110)) begin
          n_fail++;
          $display("FAIL decimal_%0d_digit%0d: An=%b Seg=%b want Seg %b", r, exp_d, An, Seg, (exp_d == 1 ? w1 : w0));
        end
      end
    end
  endtask

  task automatic test_random();
    int x, y, r;
    logic ld;
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 9) == 0);
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      r = $urandom_range(0, 31);
      tick(ld, x, y, r);
      n_checks++;
      if (An !== exp_an || Seg !== exp_seg || Dp !== 1'b1) begin
        n_fail++;
        $display("FAIL random cyc %0d: An=%b Seg=%b Dp=%b want %b %b 1", i, An, Seg, Dp, exp_an, exp_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_scan();
    test_hold();
    test_load_wrap();
    test_dig_wrap();
    test_decimal(31);
    test_decimal(7);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_display_driver.md
# sum_display_driver

Output-side counterpart of the switch/button input stage. Latches the 4-bit operands and the 5-bit adder result on a load strobe and drives them onto a 4-digit, common-anode, time-multiplexed seven-segment display. Sits between the four-bit adder core and the board display pins, clocked by the board clock.

## Interface

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot. Must be at least 2.

Ports:
- Clk  input  1  board clock; all state updates on the rising edge.
- Rst_n  input  1  reset, asynchronous, active-low.
- InputX  input  4  operand X.
- InputY  input  4  operand Y.
- Sum  input  4  adder sum bits.
- Cout  input  1  adder carry out.
- Load  input  1  capture strobe; sampled each rising Clk edge.
- An  output  4  digit anode enables, active-low; An[3] is the leftmost digit.
- Seg  output  7  segments, active-low, {g,f,e,d,c,b,a}.
- Dp  output  1  decimal point, active-low.

## Operation

- Capture registers XReg[3:0], YReg[3:0], RReg[4:0]:
  - When Load=1 at a rising edge: XReg<=InputX, YReg<=InputY, RReg<={Cout,Sum}.
  - Otherwise they hold.
- Refresh counter Cnt runs 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and digit index Dig (2 bits) increments mod 4 (3 wraps to 0).
- Digit content:
  - Dig=3: hex of XReg.
  - Dig=2: hex of YReg.
  - Dig=1: hex of {3'b000,RReg[4]}.
  - Dig=0: hex of RReg[3:0].
- Hex encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Anode select:
  - An = ~(4'b0001 << Dig).
  - An is forced to 4'b1111 (blank) for the slot's first cycle, Cnt==0. This is the anti-ghosting gap.
- Dp is held at 1 (off) at all times.
- Simultaneous Load and slot rollover: both take effect. The next slot shows the newly captured data.

## Timing

- An, Seg and Dp are registered. Each is computed from the current-cycle Cnt, Dig and capture registers, so it appears one cycle later.
- Load to display:
  - Captured value is visible on Seg one cycle after capture, whenever the relevant digit is selected.
  - Worst case is about 4×REFRESH_DIV cycles until that digit is scanned.
- Full scan period: 4×REFRESH_DIV cycles.
- Each digit is lit for REFRESH_DIV−1 cycles and blanked for 1 cycle.
- Reset values, applied immediately on Rst_n low, including mid-slot:
  - An=4'b1111, Seg=7'b1111111, Dp=1.
  - Cnt=0, Dig=0.
  - XReg=YReg=0, RReg=0.
- First release edge: Cnt=0 with Dig=0, so the first registered output after reset is blank. Digit 0 lights one cycle later.
- Load asserted during reset is ignored.

## Configuration

- Macro: SUM_DECIMAL_EN.
- Defined:
  - Digits 1..0 show RReg (0..31) in decimal: digit 1 = RReg/10, digit 0 = RReg%10.
  - A tens digit of 0 is blanked (Seg=1111111) while An still selects digit 1.
  - Conversion uses compare-subtract logic; no divider.
- Undefined: hex behaviour as described in Operation.
- Digits 3..2 are hex in both builds.

## Test plan

All scenarios use REFRESH_DIV=4.

- Reset mid-slot:
  - Stimulus: Rst_n low while Dig=2, Cnt=2.
  - Response: An=1111 and Seg=1111111 immediately, with no clock edge needed. After release, An=1111 for 1 cycle, then 1110.
- Hex scan:
  - Stimulus: Load with X=A, Y=5, Sum=F, Cout=1.
  - Response: digit 3 Seg=0001000, digit 2 0010010, digit 1 1111001, digit 0 0001110.
  - Each slot is preceded by 1 blank cycle, and the scan repeats every 16 cycles.
- Hold without Load:
  - Stimulus: change the inputs to X=3 with Load=0 for 32 cycles.
  - Response: all digits are unchanged from the previous capture.
- Load coincident with wrap:
  - Stimulus: Load X=7 at the edge where Cnt=3 and Dig=2, so Dig moves to 3.
  - Response: the digit 3 slot shows 1111000 throughout.
- Dig wrap:
  - Stimulus: run from Dig=3, Cnt=3.
  - Response: next An=1111, then 1110.
- SUM_DECIMAL_EN:
  - Stimulus: {Cout,Sum}=31.
  - Response: digit 1 Seg=0110000, digit 0 1111001.
  - With {Cout,Sum}=7: digit 1 Seg=1111111 with An=1101, digit 0 1111000.
